// File: rtl/zap_copro_responder_pkg.sv
// Shared definitions for the ZAP coprocessor responder: FSM states, instruction
// field positions, MCR/MRC recognisers, CPU mode constants and register translation.
package zap_copro_responder_pkg;

   localparam int PHY_REGS = 46;
   localparam int IW       = $clog2(PHY_REGS);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_DECODE = 2'd1,
      S_RDWAIT = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   localparam int CRN_LSB = 16;
   localparam int RD_LSB  = 12;
   localparam int CPN_LSB = 8;

   localparam logic [4:0] MODE_USR = 5'b10000;
   localparam logic [4:0] MODE_FIQ = 5'b10001;
   localparam logic [4:0] MODE_IRQ = 5'b10010;
   localparam logic [4:0] MODE_SVC = 5'b10011;
   localparam logic [4:0] MODE_ABT = 5'b10111;
   localparam logic [4:0] MODE_UND = 5'b11011;
   localparam logic [4:0] MODE_SYS = 5'b11111;

   // Physical slots above the 16 user registers hold the banked copies.
   localparam logic [IW-1:0] PHY_FIQ_R8  = IW'(16);
   localparam logic [IW-1:0] PHY_IRQ_R13 = IW'(23);
   localparam logic [IW-1:0] PHY_SVC_R13 = IW'(25);
   localparam logic [IW-1:0] PHY_ABT_R13 = IW'(27);
   localparam logic [IW-1:0] PHY_UND_R13 = IW'(29);

   function automatic logic is_mcr_word(input logic [31:0] w);
      casez (w)
         32'b????_1110_???0_????_????_????_???1_????: return 1'b1;
         default:                                    return 1'b0;
      endcase
   endfunction

   function automatic logic is_mrc_word(input logic [31:0] w);
      casez (w)
         32'b????_1110_???1_????_????_????_???1_????: return 1'b1;
         default:                                    return 1'b0;
      endcase
   endfunction

   function automatic logic [3:0] crn_of(input logic [31:0] w);
      return w[CRN_LSB +: 4];
   endfunction

   function automatic logic [3:0] rd_of(input logic [31:0] w);
      return w[RD_LSB +: 4];
   endfunction

   function automatic logic [3:0] cpn_of(input logic [31:0] w);
      return w[CPN_LSB +: 4];
   endfunction

   // Architectural Rd in the given mode -> physical register file index.
   function automatic logic [IW-1:0] translate(input logic [3:0] rd, input logic [4:0] mode);
      logic [IW-1:0] idx;
      logic          hi_pair;
      hi_pair = (rd == 4'd13) || (rd == 4'd14);
      idx     = {{(IW-4){1'b0}}, rd};
      case (mode)
         MODE_FIQ: if (rd >= 4'd8 && rd <= 4'd14) idx = PHY_FIQ_R8 + {{(IW-4){1'b0}}, rd - 4'd8};
         MODE_IRQ: if (hi_pair) idx = PHY_IRQ_R13 + {{(IW-1){1'b0}}, rd == 4'd14};
         MODE_SVC: if (hi_pair) idx = PHY_SVC_R13 + {{(IW-1){1'b0}}, rd == 4'd14};
         MODE_ABT: if (hi_pair) idx = PHY_ABT_R13 + {{(IW-1){1'b0}}, rd == 4'd14};
         MODE_UND: if (hi_pair) idx = PHY_UND_R13 + {{(IW-1){1'b0}}, rd == 4'd14};
         default:  idx = {{(IW-4){1'b0}}, rd};
      endcase
      return idx;
   endfunction

endpackage

// File: rtl/zap_copro_responder_if.sv
// Coprocessor handshake plus register-file side port between core and responder.
interface zap_copro_responder_if;
   import zap_copro_responder_pkg::*;

   logic          i_dav;
   logic [31:0]   i_cp_word;
   logic [4:0]    i_cpsr_mode;
   logic [31:0]   i_reg_rd_data;
   logic          o_done;
   logic          o_illegal;
   logic          o_reg_rd_en;
   logic [IW-1:0] o_reg_rd_index;
   logic          o_reg_wr_en;
   logic [IW-1:0] o_reg_wr_index;
   logic [31:0]   o_reg_wr_data;

   modport slave (
      input  i_dav, i_cp_word, i_cpsr_mode, i_reg_rd_data,
      output o_done, o_illegal, o_reg_rd_en, o_reg_rd_index,
             o_reg_wr_en, o_reg_wr_index, o_reg_wr_data
   );

   modport master (
      output i_dav, i_cp_word, i_cpsr_mode, i_reg_rd_data,
      input  o_done, o_illegal, o_reg_rd_en, o_reg_rd_index,
             o_reg_wr_en, o_reg_wr_index, o_reg_wr_data
   );

endinterface

// File: rtl/zap_copro_regbank.sv
// 16 x 32 coprocessor register bank: synchronous write, combinational read,
// dedicated CR1 tap, cleared by reset.
module zap_copro_regbank (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_wr_en,
   input  logic [3:0]  i_wr_addr,
   input  logic [31:0] i_wr_data,
   input  logic [3:0]  i_rd_addr,
   output logic [31:0] o_rd_data,
   output logic [31:0] o_cr1
);

   logic [31:0] r_cr [16];

   // NOTE: the array is reset explicitly because CR contents are architecturally
   // visible after reset; this keeps it in flops rather than a RAM macro.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         for (int i = 0; i < 16; i++) r_cr[i] <= '0;
      end else if (i_wr_en) begin
         r_cr[i_wr_addr] <= i_wr_data;
      end
   end

   assign o_rd_data = r_cr[i_rd_addr];
   assign o_cr1     = r_cr[1];

endmodule

// File: rtl/zap_copro_responder.sv
// ZAP coprocessor responder: executes MCR/MRC between the core register file
// and the local CR bank, answering with a level done.
module zap_copro_responder
   import zap_copro_responder_pkg::*;
#(
   parameter int CP_NUM = 15
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   zap_copro_responder_if.slave  io_cp,
   output logic [31:0]           o_cr1
);

   state_t      r_state;
   state_t      w_state_nxt;
   logic [31:0] r_word;
   logic [4:0]  r_mode;
   logic        r_illegal;
   logic        w_illegal_nxt;

   logic        w_is_mcr;
   logic        w_is_mrc;
   logic [3:0]  w_crn;
   logic [3:0]  w_rd;
   logic [IW-1:0] w_phys_rd;
   logic [31:0] w_cr_rd_data;
   logic        w_cr_wr_en;

   assign w_crn     = crn_of(r_word);
   assign w_rd      = rd_of(r_word);
   assign w_phys_rd = translate(w_rd, r_mode);
   assign w_is_mcr  = is_mcr_word(r_word) && (cpn_of(r_word) == 4'(CP_NUM));
   assign w_is_mrc  = is_mrc_word(r_word) && (cpn_of(r_word) == 4'(CP_NUM))
                      && (w_rd != 4'd15);

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state   <= S_IDLE;
         r_word    <= '0;
         r_mode    <= '0;
         r_illegal <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_illegal <= w_illegal_nxt;
         // Latch only in IDLE so a stalled initiator holding dav never re-triggers.
         if (r_state == S_IDLE && io_cp.i_dav) begin
            r_word <= io_cp.i_cp_word;
            r_mode <= io_cp.i_cpsr_mode;
         end
      end
   end

   // NOTE: every signal driven here gets a default first so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      w_state_nxt          = r_state;
      w_illegal_nxt        = r_illegal;
      w_cr_wr_en           = 1'b0;
      io_cp.o_done         = 1'b0;
      io_cp.o_illegal      = 1'b0;
      io_cp.o_reg_rd_en    = 1'b0;
      io_cp.o_reg_rd_index = '0;
      io_cp.o_reg_wr_en    = 1'b0;
      io_cp.o_reg_wr_index = '0;
      io_cp.o_reg_wr_data  = '0;

      case (r_state)
         S_IDLE: begin
            if (io_cp.i_dav) w_state_nxt = S_DECODE;
         end
         S_DECODE: begin
            if (!io_cp.i_dav) begin
               w_state_nxt = S_IDLE;
            end else if (w_is_mcr) begin
               io_cp.o_reg_rd_en    = 1'b1;
               io_cp.o_reg_rd_index = w_phys_rd;
               w_illegal_nxt        = 1'b0;
               w_state_nxt          = S_RDWAIT;
            end else if (w_is_mrc) begin
               io_cp.o_reg_wr_en    = 1'b1;
               io_cp.o_reg_wr_index = w_phys_rd;
               io_cp.o_reg_wr_data  = w_cr_rd_data;
               w_illegal_nxt        = 1'b0;
               w_state_nxt          = S_DONE;
            end else begin
               w_illegal_nxt = 1'b1;
               w_state_nxt   = S_DONE;
            end
         end
         S_RDWAIT: begin
            if (!io_cp.i_dav) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_cr_wr_en  = 1'b1;
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            io_cp.o_done    = 1'b1;
            io_cp.o_illegal = r_illegal;
            if (!io_cp.i_dav) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   zap_copro_regbank u_regbank (
      .i_clk     (i_clk),
      .i_reset   (i_reset),
      .i_wr_en   (w_cr_wr_en),
      .i_wr_addr (w_crn),
      .i_wr_data (io_cp.i_reg_rd_data),
      .i_rd_addr (w_crn),
      .o_rd_data (w_cr_rd_data),
      .o_cr1     (o_cr1)
   );

endmodule

// File: tb/tb_zap_copro_responder.sv
// Directed bench for zap_copro_responder: a transfer-level timeline model drives
// per-cycle expectations; a negedge compare process checks them.
module tb_zap_copro_responder;

   typedef enum int {K_MCR, K_MRC, K_ILL} kind_e;

   localparam logic [4:0] USR = 5'b10000;
   localparam logic [4:0] SVC = 5'b10011;

   logic        i_clk;
   logic        i_reset;
   logic [31:0] o_cr1;

   zap_copro_responder_if cp_if ();

   zap_copro_responder #(.CP_NUM(15)) dut (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .io_cp   (cp_if.slave),
      .o_cr1   (o_cr1)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   int n_checks = 0;
   int n_err    = 0;

   logic [31:0] m_cr [16];
   logic        cmp_en = 1'b0;
   logic        exp_done, exp_illegal, exp_rd_en, exp_wr_en;
   logic [5:0]  exp_rd_idx, exp_wr_idx;
   logic [31:0] exp_wr_data, exp_cr1;
   logic [5:0]  cap_idx;
   logic [31:0] cap_data;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Physical index of an architectural register: user bank is identity,
   // FIQ banks R8-R14 at 16.., IRQ/SVC/ABT/UND bank R13-R14 at 23/25/27/29.
   function automatic logic [5:0] phys(input logic [3:0] rd, input logic [4:0] mode);
      int base;
      case (mode)
         5'b10010: base = 23;
         5'b10011: base = 25;
         5'b10111: base = 27;
         5'b11011: base = 29;
         default:  base = -1;
      endcase
      if (mode == 5'b10001 && rd >= 8 && rd <= 14) return 6'(16 + int'(rd) - 8);
      if (base >= 0 && (rd == 13 || rd == 14)) return 6'(base + int'(rd) - 13);
      return 6'(rd);
   endfunction

   function automatic logic [31:0] mk(input logic l, input logic [3:0] cp,
                                      input logic [3:0] crn, input logic [3:0] rd);
      return {4'hE, 4'hE, 3'b001, l, crn, rd, cp, 3'b010, 1'b1, 4'h7};
   endfunction

   always @(negedge i_clk) begin
      if (cmp_en) begin
         check("done",    {31'd0, cp_if.o_done},      {31'd0, exp_done});
         check("illegal", {31'd0, cp_if.o_illegal},   {31'd0, exp_illegal});
         check("rd_en",   {31'd0, cp_if.o_reg_rd_en}, {31'd0, exp_rd_en});
         check("wr_en",   {31'd0, cp_if.o_reg_wr_en}, {31'd0, exp_wr_en});
         check("cr1",     o_cr1,                      exp_cr1);
         if (exp_rd_en) check("rd_index", {26'd0, cp_if.o_reg_rd_index}, {26'd0, exp_rd_idx});
         if (exp_wr_en) begin
            check("wr_index", {26'd0, cp_if.o_reg_wr_index}, {26'd0, exp_wr_idx});
            check("wr_data",  cp_if.o_reg_wr_data,            exp_wr_data);
         end
      end
   end

   task automatic next_cycle();
      @(posedge i_clk);
      #1;
      exp_done    = 1'b0;
      exp_illegal = 1'b0;
      exp_rd_en   = 1'b0;
      exp_wr_en   = 1'b0;
      exp_rd_idx  = '0;
      exp_wr_idx  = '0;
      exp_wr_data = '0;
      exp_cr1     = m_cr[1];
   endtask

   // One complete request; hold = extra cycles dav stays high after done.
   task automatic xfer(input logic [31:0] w, input kind_e k, input logic [31:0] rdata,
                       input int hold, input logic [4:0] mode);
      logic [3:0] crn, rd;
      crn = w[19:16];
      rd  = w[15:12];
      next_cycle();
      cp_if.i_dav       = 1'b1;
      cp_if.i_cp_word   = w;
      cp_if.i_cpsr_mode = mode;
      next_cycle();
      if (k == K_MCR) begin
         exp_rd_en  = 1'b1;
         exp_rd_idx = phys(rd, mode);
      end else if (k == K_MRC) begin
         exp_wr_en   = 1'b1;
         exp_wr_idx  = phys(rd, mode);
         exp_wr_data = m_cr[crn];
      end
      @(negedge i_clk);
      cap_idx  = (k == K_MRC) ? cp_if.o_reg_wr_index : cp_if.o_reg_rd_index;
      cap_data = cp_if.o_reg_wr_data;
      next_cycle();
      if (k == K_MCR) begin
         cp_if.i_reg_rd_data = rdata;
         m_cr[crn] = rdata;
         next_cycle();
      end
      for (int h = 0; h <= hold; h++) begin
         exp_done    = 1'b1;
         exp_illegal = (k == K_ILL);
         if (h == hold) cp_if.i_dav = 1'b0;
         next_cycle();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 16; i++) m_cr[i] = '0;
      i_reset             = 1'b1;
      cp_if.i_dav         = 1'b0;
      cp_if.i_cp_word     = '0;
      cp_if.i_cpsr_mode   = SVC;
      cp_if.i_reg_rd_data = '0;
      next_cycle();
      next_cycle();
      i_reset = 1'b0;
      cmp_en  = 1'b1;
      @(negedge i_clk);
      check("reset_cr1_lit", o_cr1, 32'h0);

      // MCR p15,0,R3,c1 in SVC
      xfer(mk(1'b0, 4'd15, 4'd1, 4'd3), K_MCR, 32'hDEAD_BEEF, 0, SVC);
      check("mcr_idx_lit", {26'd0, cap_idx}, 32'd3);
      @(negedge i_clk);
      check("mcr_cr1_lit", o_cr1, 32'hDEAD_BEEF);

      // MRC p15,0,R5,c1 with initiator stalled 4 cycles past done
      xfer(mk(1'b1, 4'd15, 4'd1, 4'd5), K_MRC, 32'h0, 4, SVC);
      check("mrc_data_lit", cap_data, 32'hDEAD_BEEF);
      check("mrc_idx_lit", {26'd0, cap_idx}, 32'd5);

      // Illegal requests: wrong cp#, CDP, MRC to PC, LDC
      xfer(mk(1'b1, 4'd14, 4'd1, 4'd5), K_ILL, 32'h0, 0, SVC);
      xfer(32'hEE11_3F02,                 K_ILL, 32'h0, 1, SVC);
      xfer(mk(1'b1, 4'd15, 4'd1, 4'd15), K_ILL, 32'h0, 0, SVC);
      xfer(32'hED91_1F14,                 K_ILL, 32'h0, 0, SVC);
      xfer(mk(1'b1, 4'd15, 4'd1, 4'd7), K_MRC, 32'h0, 0, SVC);

      // Flush in RDWAIT during MCR to c2
      next_cycle();
      cp_if.i_dav     = 1'b1;
      cp_if.i_cp_word = mk(1'b0, 4'd15, 4'd2, 4'd4);
      next_cycle();
      exp_rd_en  = 1'b1;
      exp_rd_idx = phys(4'd4, SVC);
      next_cycle();
      cp_if.i_dav         = 1'b0;
      cp_if.i_reg_rd_data = 32'h0000_1234;
      next_cycle();
      next_cycle();
      xfer(mk(1'b1, 4'd15, 4'd2, 4'd6), K_MRC, 32'h0, 0, SVC);
      check("flush_cr2_lit", cap_data, 32'h0);

      // Flush in DECODE: no strobe at all
      next_cycle();
      cp_if.i_dav     = 1'b1;
      cp_if.i_cp_word = mk(1'b0, 4'd15, 4'd1, 4'd2);
      next_cycle();
      cp_if.i_dav = 1'b0;
      next_cycle();

      // Banked register translation
      xfer(mk(1'b0, 4'd15, 4'd13, 4'd13), K_MCR, 32'hA5A5_0001, 0, SVC);
      check("svc_r13_idx_lit", {26'd0, cap_idx}, 32'd25);
      xfer(mk(1'b1, 4'd15, 4'd13, 4'd13), K_MRC, 32'h0, 0, USR);
      check("usr_r13_idx_lit", {26'd0, cap_idx}, 32'd13);
      check("usr_r13_data_lit", cap_data, 32'hA5A5_0001);

      // Reset while in RDWAIT
      next_cycle();
      cp_if.i_dav       = 1'b1;
      cp_if.i_cp_word   = mk(1'b0, 4'd15, 4'd1, 4'd3);
      cp_if.i_cpsr_mode = SVC;
      next_cycle();
      exp_rd_en  = 1'b1;
      exp_rd_idx = phys(4'd3, SVC);
      next_cycle();
      i_reset             = 1'b1;
      cp_if.i_reg_rd_data = 32'hBAD0_0001;
      for (int i = 0; i < 16; i++) m_cr[i] = '0;
      next_cycle();
      i_reset     = 1'b0;
      cp_if.i_dav = 1'b0;
      @(negedge i_clk);
      check("rst_mid_cr1_lit", o_cr1, 32'h0);
      next_cycle();
      xfer(mk(1'b0, 4'd15, 4'd1, 4'd3), K_MCR, 32'h0000_0C01, 1, SVC);
      @(negedge i_clk);
      check("post_rst_cr1_lit", o_cr1, 32'h0000_0C01);

      next_cycle();
      cmp_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
